// File: rtl/ysyx_23060203_pkg.sv
// Shared decode constants for the ysyx_23060203 core:
// opcodes, operation classes, immediate formats, SYSTEM encodings.
package ysyx_23060203_pkg;

  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;

  typedef enum logic [3:0] {
    CLS_ILLEGAL = 4'd0,
    CLS_ALU     = 4'd1,
    CLS_ALUI    = 4'd2,
    CLS_LOAD    = 4'd3,
    CLS_STORE   = 4'd4,
    CLS_BRANCH  = 4'd5,
    CLS_JAL     = 4'd6,
    CLS_JALR    = 4'd7,
    CLS_LUI     = 4'd8,
    CLS_AUIPC   = 4'd9,
    CLS_SYSTEM  = 4'd10
  } cls_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

endpackage

// File: rtl/ysyx_23060203_idu_imm.sv
// Immediate generator (combinational).
// Ports: inst (raw word), fmt (imm_fmt_e) in; imm (32b) out.
module ysyx_23060203_imm_gen
  import ysyx_23060203_pkg::*;
(
  input  logic [31:0] inst,
  input  imm_fmt_e    fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = 32'h0;
    unique case (fmt)
      IMM_I: imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B: imm = {{19{inst[31]}}, inst[31], inst[7],
                    inst[30:25], inst[11:8], 1'b0};
      IMM_U: imm = {inst[31:12], 12'h0};
      IMM_J: imm = {{11{inst[31]}}, inst[31], inst[19:12],
                    inst[20], inst[30:21], 1'b0};
      default: imm = 32'h0;
    endcase
  end

endmodule

// File: rtl/ysyx_23060203_idu.sv
// Decode stage: decodes one fetched word per handshake into a
// registered bundle for the EXU; in_*/out_* valid-ready, flush.
module ysyx_23060203_idu
  import ysyx_23060203_pkg::*;
#(
  parameter int NR_REG = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_inst,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic [31:0] out_imm,
  output logic [3:0]  out_cls,
  output logic [3:0]  out_alu_op,
  output logic        out_wen,
  output logic        out_ebreak,
  output logic        out_illegal
);

  localparam logic [5:0] NR = 6'(NR_REG);

  function automatic logic reg_ok(input logic [4:0] r);
    return {1'b0, r} < NR;
  endfunction

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2, rd;
  cls_e        cls;
  imm_fmt_e    fmt;
  logic        alt, use_f3, writes;
  logic        use_rs1, use_rs2, use_rd;
  logic        bad_reg, sys_bad, illegal;
  logic        wen, ebreak;
  logic [31:0] imm;

  assign op  = in_inst[6:0];
  assign f3  = in_inst[14:12];
  assign rd  = in_inst[11:7];
  assign rs1 = in_inst[19:15];
  assign rs2 = in_inst[24:20];

  always_comb begin
    cls     = CLS_ILLEGAL;
    fmt     = IMM_NONE;
    alt     = 1'b0;
    use_f3  = 1'b0;
    writes  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    unique case (1'b1)
      (op == OP_ALU): begin
        cls = CLS_ALU; alt = in_inst[30]; use_f3 = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
        writes = 1'b1;
      end
      (op == OP_ALUI): begin
        cls = CLS_ALUI; fmt = IMM_I; use_f3 = 1'b1;
        // only SRAI/SRLI carry a real alt bit
        alt = (f3 == 3'b101) & in_inst[30];
        use_rs1 = 1'b1; use_rd = 1'b1; writes = 1'b1;
      end
      (op == OP_LOAD): begin
        cls = CLS_LOAD; fmt = IMM_I; use_f3 = 1'b1;
        use_rs1 = 1'b1; use_rd = 1'b1; writes = 1'b1;
      end
      (op == OP_STORE): begin
        cls = CLS_STORE; fmt = IMM_S; use_f3 = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      (op == OP_BRANCH): begin
        cls = CLS_BRANCH; fmt = IMM_B; use_f3 = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      (op == OP_JAL): begin
        cls = CLS_JAL; fmt = IMM_J;
        use_rd = 1'b1; writes = 1'b1;
      end
      (op == OP_JALR): begin
        cls = CLS_JALR; fmt = IMM_I;
        use_rs1 = 1'b1; use_rd = 1'b1; writes = 1'b1;
      end
      (op == OP_LUI): begin
        cls = CLS_LUI; fmt = IMM_U;
        use_rd = 1'b1; writes = 1'b1;
      end
      (op == OP_AUIPC): begin
        cls = CLS_AUIPC; fmt = IMM_U;
        use_rd = 1'b1; writes = 1'b1;
      end
      (op == OP_SYSTEM): cls = CLS_SYSTEM;
      default: ;
    endcase

    bad_reg = (use_rs1 && !reg_ok(rs1)) ||
              (use_rs2 && !reg_ok(rs2)) ||
              (use_rd  && !reg_ok(rd));
    // only ECALL/EBREAK are supported in SYSTEM space
    sys_bad = (cls == CLS_SYSTEM) &&
              (in_inst != INST_ECALL) &&
              (in_inst != INST_EBREAK);
    illegal = (cls == CLS_ILLEGAL) ||
              (in_inst[1:0] != 2'b11) ||
              bad_reg || sys_bad;
    wen     = writes && (rd != 5'd0) && !illegal;
    ebreak  = (in_inst == INST_EBREAK) && !illegal;
  end

  ysyx_23060203_imm_gen u_imm (
    .inst (in_inst),
    .fmt  (fmt),
    .imm  (imm)
  );

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid   <= 1'b0;
      out_pc      <= 32'h0;
      out_rs1     <= 5'd0;
      out_rs2     <= 5'd0;
      out_rd      <= 5'd0;
      out_imm     <= 32'h0;
      out_cls     <= CLS_ILLEGAL;
      out_alu_op  <= 4'h0;
      out_wen     <= 1'b0;
      out_ebreak  <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_rs1     <= rs1;
      out_rs2     <= rs2;
      out_rd      <= rd;
      out_imm     <= imm;
      out_cls     <= cls;
      out_alu_op  <= {alt, use_f3 ? f3 : 3'b000};
      out_wen     <= wen;
      out_ebreak  <= ebreak;
      out_illegal <= illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/ysyx_23060203_idu.md
# ysyx_23060203_idu

Instruction decode stage between the fetch unit and the execute unit of the ysyx_23060203 core. It accepts one fetched instruction word and its PC per handshake. It decodes RV32I/RV32E fields, the immediate, the operation class and the ALU op, and holds the result in a single output register stage for the EXU. It also flags illegal encodings and EBREAK, and supports a one-cycle pipeline flush on redirect.

## Interface
- NR_REG, 16: architectural register count (16 = RV32E, 32 = RV32I). A register index ≥ NR_REG is illegal.
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- in_valid  in  1  fetch result valid
- in_ready  out  1  stage can accept this cycle
- in_pc  in  32  PC of in_inst
- in_inst  in  32  raw instruction word
- flush  in  1  discard held and incoming instruction (branch/jump redirect)
- out_valid  out  1  decoded instruction valid
- out_ready  in  1  EXU accepts
- out_pc  out  32  registered PC
- out_rs1, out_rs2, out_rd  out  5 each  register indices, taken from inst[19:15], inst[24:20], inst[11:7]
- out_imm  out  32  sign/zero-extended immediate
- out_cls  out  4  operation class (package enum)
- out_alu_op  out  4  {alt, funct3}
- out_wen  out  1  writes rd (rd ≠ 0 and class writes)
- out_ebreak  out  1  instruction == 32'h00100073
- out_illegal  out  1  undecodable or register index out of range

## Operation
- Classes: ALU (0110011), ALUI (0010011), LOAD (0000011), STORE (0100011), BRANCH (1100011), JAL (1101111), JALR (1100111), LUI (0110111), AUIPC (0010111), SYSTEM (1110011), ILLEGAL (any other opcode).
- Immediate formats:
  - I: inst[31:20] sign-extended.
  - S: {inst[31:25], inst[11:7]} sign-extended.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0} sign-extended.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0} sign-extended.
  - ALU and SYSTEM: 0.
- alu_op: alt = inst[30] for ALU. For ALUI, alt = inst[30] only when funct3 == 101, otherwise 0. LOAD/STORE/BRANCH pass funct3 with alt = 0. Other classes use 0.
- wen = 1 for ALU, ALUI, LOAD, JAL, JALR, LUI, AUIPC when rd ≠ 0; 0 otherwise.
- illegal when any of the following hold:
  - opcode is unknown;
  - inst[1:0] ≠ 11;
  - a used rs1/rs2/rd index ≥ NR_REG;
  - SYSTEM and the instruction is not exactly ECALL (32'h00000073) or EBREAK.
- Illegal takes priority: when illegal, wen = 0 and ebreak = 0.
- The IFU reset filler 32'hffffffff decodes as illegal. It never asserts wen.

## Timing
- Latency 1 cycle: accept at edge N, so out_valid = 1 after edge N. Throughput 1 instruction/cycle.
- in_ready = !out_valid || out_ready. It is combinational, with no dependence on in_valid.
- Accept happens when in_valid && in_ready && !flush. The output register loads all fields and out_valid ← 1.
- When out_valid && !out_ready && !flush, all outputs hold stable.
- Output consumed with no new accept: out_valid ← 0, and fields hold their last value.
- flush (highest priority): out_valid ← 0 at the next edge. A same-cycle in_valid is dropped, even if in_ready = 1.
- Reset (rstn = 0 at an edge): out_valid = 0, out_pc = 0, out_inst-derived fields = 0, out_cls = ILLEGAL encoding 0, out_illegal = 0, out_ebreak = 0. Reset mid-handshake drops the held instruction.

## Structure
- Package ysyx_23060203_pkg holds:
  - opcode constants;
  - cls enum (4 bits);
  - imm-format enum;
  - EBREAK and ECALL encodings.
- Sub-module ysyx_23060203_imm_gen is combinational: inst and format in, 32-bit immediate out.
- The top level contains the decode logic, the valid/ready control and the output register.

## Test plan
- ADDI x1,x0,5 (0x00500093), out_ready = 1: one cycle later out_valid = 1, cls = ALUI, rd = 1, rs1 = 0, imm = 5, alu_op = 0000, wen = 1.
- BEQ x0,x0,-4 (0xfe000ee3): cls = BRANCH, imm = 0xfffffffc, wen = 0, illegal = 0.
- Backpressure: hold out_ready = 0 for 3 cycles after accepting 0x00500093. in_ready = 0, outputs stay stable, and the next instruction is accepted in the cycle out_ready = 1.
- Flush: assert flush with out_valid = 1 and in_valid = 1 (0x00000833). Next cycle out_valid = 0 and the incoming instruction never appears.
- Illegal: 0xffffffff gives illegal = 1, wen = 0. With NR_REG = 16, 0x00000833 (add x16) gives illegal = 1. With NR_REG = 32 it gives illegal = 0, wen = 1.
- EBREAK 0x00100073: cls = SYSTEM, ebreak = 1, illegal = 0. Then rstn = 0 for one edge: out_valid = 0, ebreak = 0.
